// File: rtl/fetch_predict_stage.sv
// -----------------------------------------------------------------------------
// fetch_predict_stage
//
// Fetch stage with a direct-mapped branch target buffer (BTB) and the F/D
// pipeline register. The BTB is looked up combinationally on PCF to choose the
// next fetch address, trained from branches resolving in Execute, and a
// misprediction detected in Execute redirects fetch and clears F/D.
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   StallF, StallD      hold PCF / hold the F/D register
//   FlushD              clear the F/D register
//   InstrF              instruction memory read data for PCF
//   PCF                 current fetch address
//   PCD, InstrD,
//   PCPlus4D            Decode-side copy of the fetched instruction
//   PredTakenD,
//   PredTargetD         prediction made for PCD, carried for later checking
//   UpdateE, TakenE,
//   PCE, PCTargetE,
//   PCPlus4E            branch/jump resolution from Execute
//   PredTakenE,
//   PredTargetE         prediction that was made for the resolving instruction
//   RedirectE           misprediction (combinational)
// -----------------------------------------------------------------------------
module fetch_predict_stage #(
   parameter int                    PC_WIDTH    = 12,
   parameter int                    INSTR_WIDTH = 32,
   parameter int                    BTB_ENTRIES = 16,
   parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     StallF,
   input  logic                     StallD,
   input  logic                     FlushD,
   input  logic [INSTR_WIDTH-1:0]   InstrF,
   output logic [PC_WIDTH-1:0]      PCF,
   output logic [PC_WIDTH-1:0]      PCD,
   output logic [INSTR_WIDTH-1:0]   InstrD,
   output logic [PC_WIDTH-1:0]      PCPlus4D,
   output logic                     PredTakenD,
   output logic [PC_WIDTH-1:0]      PredTargetD,
   input  logic                     UpdateE,
   input  logic                     TakenE,
   input  logic [PC_WIDTH-1:0]      PCE,
   input  logic [PC_WIDTH-1:0]      PCTargetE,
   input  logic [PC_WIDTH-1:0]      PCPlus4E,
   input  logic                     PredTakenE,
   input  logic [PC_WIDTH-1:0]      PredTargetE,
   output logic                     RedirectE
);

   localparam int                  IDX_W   = $clog2(BTB_ENTRIES);
   localparam int                  TAG_W   = PC_WIDTH - IDX_W - 2;
   localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);
   localparam logic [1:0]          CTR_INIT  = 2'b01;
   localparam logic [1:0]          CTR_ALLOC = 2'b10;

   // Fetch PC and F/D register
   logic [PC_WIDTH-1:0]    pcf_q, pcf_d;
   logic [PC_WIDTH-1:0]    pcd_q, pcd_d;
   logic [INSTR_WIDTH-1:0] instrd_q, instrd_d;
   logic [PC_WIDTH-1:0]    pcplus4d_q, pcplus4d_d;
   logic                   predtakend_q, predtakend_d;
   logic [PC_WIDTH-1:0]    predtargetd_q, predtargetd_d;

   // BTB storage
   logic [BTB_ENTRIES-1:0]               btb_valid_q, btb_valid_d;
   logic [BTB_ENTRIES-1:0][TAG_W-1:0]    btb_tag_q, btb_tag_d;
   logic [BTB_ENTRIES-1:0][PC_WIDTH-1:0] btb_target_q, btb_target_d;
   logic [BTB_ENTRIES-1:0][1:0]          btb_ctr_q, btb_ctr_d;

   // Lookup / resolve helpers
   logic [IDX_W-1:0]       lookup_idx, update_idx;
   logic [TAG_W-1:0]       lookup_tag, update_tag;
   logic                   hit_f, hit_e;
   logic                   pred_taken_f;
   logic [PC_WIDTH-1:0]    pred_target_f;
   logic [PC_WIDTH-1:0]    pcplus4_f;
   logic                   redirect;
   logic                   clear_d;

   // PCE is word aligned; its byte-offset bits carry no BTB information.
   logic                   unused_pce_bits;
   assign unused_pce_bits = ^PCE[1:0];

   // ---------------------------------------------------------------------------
   // Fetch-side lookup and misprediction detection
   // ---------------------------------------------------------------------------
   always_comb begin
      lookup_idx    = pcf_q[IDX_W+1:2];
      lookup_tag    = pcf_q[PC_WIDTH-1:IDX_W+2];
      hit_f         = btb_valid_q[lookup_idx] && (btb_tag_q[lookup_idx] == lookup_tag);
      pred_taken_f  = hit_f && btb_ctr_q[lookup_idx][1];
      pred_target_f = btb_target_q[lookup_idx];
      pcplus4_f     = pcf_q + PC_STEP;

      // A taken branch predicted taken can still mispredict on a stale target.
      redirect = UpdateE &&
                 ((TakenE != PredTakenE) ||
                  (TakenE && PredTakenE && (PCTargetE != PredTargetE)));
   end

   assign RedirectE = redirect;

   // ---------------------------------------------------------------------------
   // Next PC and F/D register
   // ---------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default assignment first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      pcf_d = pcplus4_f;
      if (redirect) begin
         pcf_d = TakenE ? PCTargetE : PCPlus4E;
      end else if (StallF) begin
         pcf_d = pcf_q;
      end else if (pred_taken_f) begin
         pcf_d = pred_target_f;
      end

      pcd_d         = pcf_q;
      instrd_d      = InstrF;
      pcplus4d_d    = pcplus4_f;
      predtakend_d  = pred_taken_f;
      predtargetd_d = pred_target_f;

      // The instruction in F/D is on the wrong path after a mispredict, so the
      // clear must win over a Decode stall.
      clear_d = FlushD || redirect;
      if (clear_d) begin
         pcd_d         = '0;
         instrd_d      = '0;
         pcplus4d_d    = '0;
         predtakend_d  = 1'b0;
         predtargetd_d = '0;
      end else if (StallD) begin
         pcd_d         = pcd_q;
         instrd_d      = instrd_q;
         pcplus4d_d    = pcplus4d_q;
         predtakend_d  = predtakend_q;
         predtargetd_d = predtargetd_q;
      end
   end

   // ---------------------------------------------------------------------------
   // BTB training from Execute
   // ---------------------------------------------------------------------------
   always_comb begin
      btb_valid_d  = btb_valid_q;
      btb_tag_d    = btb_tag_q;
      btb_target_d = btb_target_q;
      btb_ctr_d    = btb_ctr_q;

      update_idx = PCE[IDX_W+1:2];
      update_tag = PCE[PC_WIDTH-1:IDX_W+2];
      hit_e      = btb_valid_q[update_idx] && (btb_tag_q[update_idx] == update_tag);

      if (UpdateE) begin
         if (hit_e && TakenE) begin
            if (btb_ctr_q[update_idx] != 2'b11) begin
               btb_ctr_d[update_idx] = btb_ctr_q[update_idx] + 2'b01;
            end
            btb_target_d[update_idx] = PCTargetE;
         end else if (hit_e) begin
            if (btb_ctr_q[update_idx] != 2'b00) begin
               btb_ctr_d[update_idx] = btb_ctr_q[update_idx] - 2'b01;
            end
         end else if (TakenE) begin
            // Direct mapped: a taken miss simply evicts whatever aliases here.
            btb_valid_d[update_idx]  = 1'b1;
            btb_tag_d[update_idx]    = update_tag;
            btb_target_d[update_idx] = PCTargetE;
            btb_ctr_d[update_idx]    = CTR_ALLOC;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pcf_q         <= RESET_PC;
         pcd_q         <= '0;
         instrd_q      <= '0;
         pcplus4d_q    <= '0;
         predtakend_q  <= 1'b0;
         predtargetd_q <= '0;
      end else begin
         pcf_q         <= pcf_d;
         pcd_q         <= pcd_d;
         instrd_q      <= instrd_d;
         pcplus4d_q    <= pcplus4d_d;
         predtakend_q  <= predtakend_d;
         predtargetd_q <= predtargetd_d;
      end
   end

   // NOTE: the BTB is built from flops rather than a RAM macro because reset
   // must invalidate every entry and preset its counter in one step; only the
   // valid bits and counters need it, but tags/targets share the process.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         btb_valid_q  <= '0;
         btb_tag_q    <= '0;
         btb_target_q <= '0;
         btb_ctr_q    <= {BTB_ENTRIES{CTR_INIT}};
      end else begin
         btb_valid_q  <= btb_valid_d;
         btb_tag_q    <= btb_tag_d;
         btb_target_q <= btb_target_d;
         btb_ctr_q    <= btb_ctr_d;
      end
   end

   assign PCF         = pcf_q;
   assign PCD         = pcd_q;
   assign InstrD      = instrd_q;
   assign PCPlus4D    = pcplus4d_q;
   assign PredTakenD  = predtakend_q;
   assign PredTargetD = predtargetd_q;

endmodule

// File: tb/tb_fetch_predict_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_predict_stage
//
// Directed bench for fetch_predict_stage at default parameters. Instruction
// memory is modelled as a constant upper field concatenated with the PC, so
// the expected InstrD is derived from the expected PCD.
// -----------------------------------------------------------------------------
module tb_fetch_predict_stage;

   localparam logic [19:0] IMEM_TAG = 20'hC0DE0;

   logic        clock;
   logic        reset;
   logic        StallF, StallD, FlushD;
   logic [31:0] InstrF;
   logic [11:0] PCF, PCD, PCPlus4D, PredTargetD;
   logic [31:0] InstrD;
   logic        PredTakenD;
   logic        UpdateE, TakenE, PredTakenE;
   logic [11:0] PCE, PCTargetE, PCPlus4E, PredTargetE;
   logic        RedirectE;

   int tests_run    = 0;
   int tests_failed = 0;

   fetch_predict_stage dut (
      .clock       (clock),
      .reset       (reset),
      .StallF      (StallF),
      .StallD      (StallD),
      .FlushD      (FlushD),
      .InstrF      (InstrF),
      .PCF         (PCF),
      .PCD         (PCD),
      .InstrD      (InstrD),
      .PCPlus4D    (PCPlus4D),
      .PredTakenD  (PredTakenD),
      .PredTargetD (PredTargetD),
      .UpdateE     (UpdateE),
      .TakenE      (TakenE),
      .PCE         (PCE),
      .PCTargetE   (PCTargetE),
      .PCPlus4E    (PCPlus4E),
      .PredTakenE  (PredTakenE),
      .PredTargetE (PredTargetE),
      .RedirectE   (RedirectE)
   );

   assign InstrF = {IMEM_TAG, PCF};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Drive one resolution for a single cycle, checking RedirectE before the edge.
   task automatic resolve(input string name, input logic [11:0] pce, input logic taken,
                          input logic [11:0] tgt, input logic [11:0] plus4,
                          input logic ptaken, input logic [11:0] ptgt, input logic exp_red);
      UpdateE = 1'b1; PCE = pce; TakenE = taken; PCTargetE = tgt;
      PCPlus4E = plus4; PredTakenE = ptaken; PredTargetE = ptgt;
      #1;
      tests_run++;
      if (RedirectE !== exp_red) begin
         tests_failed++;
         $display("FAIL %s_redirect: got %b want %b", name, RedirectE, exp_red);
      end
      step();
      UpdateE = 1'b0; TakenE = 1'b0; PredTakenE = 1'b0;
      PCE = '0; PCTargetE = '0; PCPlus4E = '0; PredTargetE = '0;
   endtask

   // Steer fetch to pc with a not-taken mispredict on a PC whose BTB slot is
   // never used, so the BTB is left untouched.
   task automatic goto_pc(input logic [11:0] pc);
      resolve("goto", 12'hFF8, 1'b0, 12'h000, pc, 1'b1, 12'h000, 1'b1);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      tests_run++;
      if (PCF !== 12'h000 || PCD !== 12'h000 || InstrD !== 32'h0 ||
          PCPlus4D !== 12'h000 || PredTakenD !== 1'b0 || PredTargetD !== 12'h000) begin
         tests_failed++;
         $display("FAIL reset_state: PCF=%h PCD=%h InstrD=%h PCPlus4D=%h PT=%b PTgt=%h want all 0",
                  PCF, PCD, InstrD, PCPlus4D, PredTakenD, PredTargetD);
      end
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_sequential();
      tests_run++;
      if (PCF !== 12'h000) begin
         tests_failed++; $display("FAIL seq_pcf0: got %h want 000", PCF);
      end
      step();
      tests_run++;
      if (PCF !== 12'h004 || PCD !== 12'h000 || InstrD !== {IMEM_TAG, 12'h000} ||
          PCPlus4D !== 12'h004 || PredTakenD !== 1'b0) begin
         tests_failed++;
         $display("FAIL seq_step1: PCF=%h PCD=%h InstrD=%h PCPlus4D=%h PT=%b want 004 000 c0de0000 004 0",
                  PCF, PCD, InstrD, PCPlus4D, PredTakenD);
      end
      step();
      tests_run++;
      if (PCF !== 12'h008 || PCD !== 12'h004) begin
         tests_failed++; $display("FAIL seq_step2: PCF=%h PCD=%h want 008 004", PCF, PCD);
      end
   endtask

   task automatic test_wrap();
      goto_pc(12'hFFC);
      tests_run++;
      if (PCF !== 12'hFFC || PCD !== 12'h000 || InstrD !== 32'h0) begin
         tests_failed++; $display("FAIL wrap_goto: PCF=%h PCD=%h InstrD=%h want ffc 000 0", PCF, PCD, InstrD);
      end
      step();
      tests_run++;
      if (PCF !== 12'h000 || PCD !== 12'hFFC || PCPlus4D !== 12'h000 ||
          InstrD !== {IMEM_TAG, 12'hFFC}) begin
         tests_failed++;
         $display("FAIL wrap_step: PCF=%h PCD=%h PCPlus4D=%h InstrD=%h want 000 ffc 000 c0de0ffc",
                  PCF, PCD, PCPlus4D, InstrD);
      end
   endtask

   task automatic test_allocate();
      resolve("alloc", 12'h010, 1'b1, 12'h040, 12'h014, 1'b0, 12'h000, 1'b1);
      tests_run++;
      if (PCF !== 12'h040 || InstrD !== 32'h0 || PCD !== 12'h000) begin
         tests_failed++; $display("FAIL alloc_redirect_pc: PCF=%h InstrD=%h PCD=%h want 040 0 000", PCF, InstrD, PCD);
      end
      goto_pc(12'h010);
      step();
      tests_run++;
      if (PCD !== 12'h010 || PredTakenD !== 1'b1 || PredTargetD !== 12'h040 || PCF !== 12'h040) begin
         tests_failed++;
         $display("FAIL alloc_predict: PCD=%h PT=%b PTgt=%h PCF=%h want 010 1 040 040",
                  PCD, PredTakenD, PredTargetD, PCF);
      end
   endtask

   task automatic test_not_taken();
      resolve("nt1", 12'h010, 1'b0, 12'h000, 12'h014, 1'b1, 12'h040, 1'b1);
      tests_run++;
      if (PCF !== 12'h014) begin
         tests_failed++; $display("FAIL nt1_pcf: got %h want 014", PCF);
      end
      resolve("nt2", 12'h010, 1'b0, 12'h000, 12'h014, 1'b0, 12'h000, 1'b0);
      tests_run++;
      if (PCF !== 12'h018) begin
         tests_failed++; $display("FAIL nt2_pcf: got %h want 018", PCF);
      end
      goto_pc(12'h010);
      step();
      tests_run++;
      if (PCD !== 12'h010 || PredTakenD !== 1'b0 || PCF !== 12'h014) begin
         tests_failed++; $display("FAIL nt_predict: PCD=%h PT=%b PCF=%h want 010 0 014", PCD, PredTakenD, PCF);
      end
      // Counter is now 00; two taken hits bring it back to 10.
      resolve("retrain1", 12'h010, 1'b1, 12'h040, 12'h014, 1'b0, 12'h000, 1'b1);
      goto_pc(12'h010);
      step();
      tests_run++;
      if (PredTakenD !== 1'b0) begin
         tests_failed++; $display("FAIL retrain_ctr01: PT=%b want 0", PredTakenD);
      end
      resolve("retrain2", 12'h010, 1'b1, 12'h040, 12'h014, 1'b0, 12'h000, 1'b1);
      goto_pc(12'h010);
      step();
      tests_run++;
      if (PredTakenD !== 1'b1 || PredTargetD !== 12'h040 || PCF !== 12'h040) begin
         tests_failed++;
         $display("FAIL retrain_ctr10: PT=%b PTgt=%h PCF=%h want 1 040 040", PredTakenD, PredTargetD, PCF);
      end
   endtask

   task automatic test_alias();
      goto_pc(12'h050);
      step();
      tests_run++;
      if (PCD !== 12'h050 || PredTakenD !== 1'b0 || PCF !== 12'h054) begin
         tests_failed++; $display("FAIL alias_lookup: PCD=%h PT=%b PCF=%h want 050 0 054", PCD, PredTakenD, PCF);
      end
      resolve("alias_alloc", 12'h050, 1'b1, 12'h080, 12'h054, 1'b0, 12'h000, 1'b1);
      tests_run++;
      if (PCF !== 12'h080) begin
         tests_failed++; $display("FAIL alias_alloc_pcf: got %h want 080", PCF);
      end
      goto_pc(12'h010);
      step();
      tests_run++;
      if (PredTakenD !== 1'b0 || PCF !== 12'h014) begin
         tests_failed++; $display("FAIL alias_evicted: PT=%b PCF=%h want 0 014", PredTakenD, PCF);
      end
      goto_pc(12'h050);
      step();
      tests_run++;
      if (PredTakenD !== 1'b1 || PredTargetD !== 12'h080 || PCF !== 12'h080) begin
         tests_failed++;
         $display("FAIL alias_new_entry: PT=%b PTgt=%h PCF=%h want 1 080 080", PredTakenD, PredTargetD, PCF);
      end
   endtask

   task automatic test_same_cycle();
      goto_pc(12'h050);
      // Correctly predicted taken resolve at 0x010 evicts 0x050 this very cycle.
      resolve("same_cycle", 12'h010, 1'b1, 12'h0C0, 12'h014, 1'b1, 12'h0C0, 1'b0);
      tests_run++;
      if (PCD !== 12'h050 || PredTakenD !== 1'b1 || PredTargetD !== 12'h080 || PCF !== 12'h080) begin
         tests_failed++;
         $display("FAIL same_cycle_old_view: PCD=%h PT=%b PTgt=%h PCF=%h want 050 1 080 080",
                  PCD, PredTakenD, PredTargetD, PCF);
      end
      goto_pc(12'h050);
      step();
      tests_run++;
      if (PredTakenD !== 1'b0 || PCF !== 12'h054) begin
         tests_failed++; $display("FAIL same_cycle_evicted: PT=%b PCF=%h want 0 054", PredTakenD, PCF);
      end
      goto_pc(12'h010);
      step();
      tests_run++;
      if (PredTakenD !== 1'b1 || PredTargetD !== 12'h0C0 || PCF !== 12'h0C0) begin
         tests_failed++;
         $display("FAIL same_cycle_new_view: PT=%b PTgt=%h PCF=%h want 1 0c0 0c0", PredTakenD, PredTargetD, PCF);
      end
   endtask

   task automatic test_stall();
      goto_pc(12'h200);
      step();
      StallF = 1'b1; StallD = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         tests_run++;
         if (PCF !== 12'h204 || PCD !== 12'h200 || InstrD !== {IMEM_TAG, 12'h200}) begin
            tests_failed++;
            $display("FAIL stall_hold_%0d: PCF=%h PCD=%h InstrD=%h want 204 200 c0de0200", i, PCF, PCD, InstrD);
         end
      end
      resolve("stall_redirect", 12'h300, 1'b1, 12'h340, 12'h304, 1'b0, 12'h000, 1'b1);
      tests_run++;
      if (PCF !== 12'h340 || PCD !== 12'h000 || InstrD !== 32'h0 || PredTakenD !== 1'b0) begin
         tests_failed++;
         $display("FAIL stall_redirect_state: PCF=%h PCD=%h InstrD=%h PT=%b want 340 000 0 0",
                  PCF, PCD, InstrD, PredTakenD);
      end
      step();
      tests_run++;
      if (PCF !== 12'h340 || PCD !== 12'h000) begin
         tests_failed++; $display("FAIL stall_after_redirect: PCF=%h PCD=%h want 340 000", PCF, PCD);
      end
      StallF = 1'b0; StallD = 1'b0;
      step();
      tests_run++;
      if (PCF !== 12'h344 || PCD !== 12'h340) begin
         tests_failed++; $display("FAIL stall_release: PCF=%h PCD=%h want 344 340", PCF, PCD);
      end
      FlushD = 1'b1;
      step();
      FlushD = 1'b0;
      tests_run++;
      if (PCF !== 12'h348 || PCD !== 12'h000 || InstrD !== 32'h0) begin
         tests_failed++; $display("FAIL flushd: PCF=%h PCD=%h InstrD=%h want 348 000 0", PCF, PCD, InstrD);
      end
   endtask

   task automatic test_async_reset();
      goto_pc(12'h1A0);
      step();
      tests_run++;
      if (PCF !== 12'h1A4 || PCD !== 12'h1A0) begin
         tests_failed++; $display("FAIL areset_setup: PCF=%h PCD=%h want 1a4 1a0", PCF, PCD);
      end
      // A taken update is pending when reset hits; it must be discarded.
      UpdateE = 1'b1; PCE = 12'h000; TakenE = 1'b1; PCTargetE = 12'h100; PredTakenE = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if (PCF !== 12'h000 || PCD !== 12'h000 || InstrD !== 32'h0 ||
          PCPlus4D !== 12'h000 || PredTakenD !== 1'b0 || PredTargetD !== 12'h000) begin
         tests_failed++;
         $display("FAIL areset_immediate: PCF=%h PCD=%h InstrD=%h PCPlus4D=%h PT=%b PTgt=%h want all 0",
                  PCF, PCD, InstrD, PCPlus4D, PredTakenD, PredTargetD);
      end
      UpdateE = 1'b0; TakenE = 1'b0; PCE = '0; PCTargetE = '0;
      step();
      reset = 1'b0;
      step();
      tests_run++;
      if (PCF !== 12'h004) begin
         tests_failed++; $display("FAIL areset_update_dropped: PCF=%h want 004", PCF);
      end
      step(); step(); step();
      step();
      tests_run++;
      if (PCD !== 12'h010 || PredTakenD !== 1'b0 || PCF !== 12'h014) begin
         tests_failed++;
         $display("FAIL areset_btb_cleared: PCD=%h PT=%b PCF=%h want 010 0 014", PCD, PredTakenD, PCF);
      end
   endtask

   initial begin
      StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
      UpdateE = 1'b0; TakenE = 1'b0; PredTakenE = 1'b0;
      PCE = '0; PCTargetE = '0; PCPlus4E = '0; PredTargetE = '0;
      test_reset();
      test_sequential();
      test_wrap();
      test_allocate();
      test_not_taken();
      test_alias();
      test_same_cycle();
      test_stall();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
